dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the MIPS core load/store path and a debug/loader port used for memory preload and inspection.
- Sits between the core's memory-stage signals and the data memory instance.
- Stalls the core while the memory is busy or granted to the debug port.
- Core has fixed priority; a starvation counter guarantees debug forward progress.

Parameters:
ADDR_W, 32, byte/word address width passed through to memory
DATA_W, 32, data word width
STARVE_LIM, 4, consecutive cycles of denied dbg_req after which debug wins the next issue slot (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
core_req  in  1  core memory access request (held until core_stall low)
core_we  in  1  1 = store, 0 = load
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core store data
core_rdata  out  DATA_W  load data, valid in cycle core_stall drops for a load
core_stall  out  1  freeze PC/pipeline this cycle
dbg_req  in  1  debug request (held until dbg_ack)
dbg_we  in  1  debug write enable
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  debug read data, valid with dbg_ack
dbg_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, 1 cycle after read issue

Behaviour:
- Reset (reset=0, async): state=IDLE, starve_cnt=0, dbg_ack=0, dbg_rdata=0, mem_en=0, mem_we=0, core_stall=1, core_rdata=0. Any in-flight read is discarded; no ack is issued for it.
- States:
  - IDLE: issue slot available.
  - C_RD: core read data phase.
  - D_RD: debug read data phase.
- Issue occurs only in IDLE. No issue is made in C_RD or D_RD (mem_en=0).
- Arbitration in IDLE:
  - Debug wins if dbg_req and (starve_cnt==STARVE_LIM or !core_req).
  - Otherwise the core wins if core_req.
- starve_cnt:
  - Increments (saturating at STARVE_LIM) each cycle dbg_req=1 and debug not granted.
  - Clears on debug grant or when dbg_req=0.
- Core write grant: mem_en=1, mem_we=1, core_stall=0 in the same cycle (commit at edge). State stays IDLE.
- Core read grant: mem_en=1, mem_we=0, core_stall=1, then go to C_RD. In C_RD: core_stall=0, core_rdata=mem_rdata, then go to IDLE. Total load latency is 2 cycles.
- Debug write grant: mem driven from dbg_*, dbg_ack registered high next cycle, state stays IDLE.
- Debug read grant: go to D_RD. In D_RD, dbg_rdata<=mem_rdata and dbg_ack pulses high the following cycle; return to IDLE.
- core_stall=1 whenever core_req=1 and the core is not completing this cycle. core_stall=0 when core_req=0.
- mem_* outputs are combinational from state and the granted requester. mem_addr, mem_wdata and mem_we are 0 when mem_en=0.
- Simultaneous core_req and dbg_req with starve_cnt<STARVE_LIM: core wins.
- Back-to-back debug writes:
  - Requester drops or re-presents dbg_req after ack.
  - A request held through the ack cycle is treated as a new request.

Decomposition:
- Shared package/header holds state encodings (IDLE=2'd0, C_RD=2'd1, D_RD=2'd2) and the default STARVE_LIM.
- One sub-module is natural: starve_counter, a saturating counter with clear and limit-hit output.
- Grant mux and FSM stay in dmem_arbiter.

Test Plan:
- Reset held 0, then released; idle inputs -> mem_en=0, dbg_ack=0, core_stall=0 after release, core_stall=1 during reset.
- Core store addr 0x28 data 20, then core load 0x28 -> store completes with no stall. Load stalls exactly 1 cycle; core_rdata=20 in cycle 2.
- Debug write 0x10=0xA5A5, then debug read 0x10 -> dbg_ack 1 cycle after the write. Read ack carries dbg_rdata=0xA5A5.
- Core load continuously asserted plus dbg_req held, STARVE_LIM=4 -> debug is granted within 4 denied cycles. starve_cnt clears and the core resumes afterwards.
- Simultaneous core_req and dbg_req with starve_cnt=0 -> core granted first; debug served on the next IDLE slot.
- reset asserted during C_RD -> state IDLE, core_rdata=0, no spurious dbg_ack. A fresh core load after release returns correct data.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Holds FSM state encodings and starvation-counter sizing.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      C_RD = 2'd1,
      D_RD = 2'd2
   } arb_state_t;

   localparam int STARVE_LIM_DEF = 4;
   localparam int CNT_W          = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating starvation counter with clear and limit-hit flag.
// Ports: clk, reset (async low), inc, clr -> cnt, hit.
module starve_counter
   import dmem_arbiter_pkg::*;
#(
   parameter int LIM = STARVE_LIM_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             hit
);

   localparam logic [CNT_W-1:0] LIM_C = CNT_W'(LIM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && cnt != LIM_C) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign hit = (cnt == LIM_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one sync data memory between the core load/store path
// and a debug/loader port. Core has priority; debug is protected
// from starvation. Ports: core_*, dbg_*, mem_*, clk, reset (async low).
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = STARVE_LIM_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state;
   logic [DATA_W-1:0] core_rdata_q;
   logic [CNT_W-1:0]  starve_cnt;
   logic              starve_hit;
   logic              dbg_live;
   logic              in_idle;
   logic              dbg_grant;
   logic              core_grant;
   logic              core_done;
   logic              cnt_clr;

   // dbg_req is still up in its own ack cycle; that is the old
   // request, so it must not be granted again there.
   assign dbg_live = dbg_req & ~dbg_ack;

   assign in_idle    = reset & (state == IDLE);
   assign dbg_grant  = in_idle & dbg_live
                     & (starve_hit | ~core_req);
   assign core_grant = in_idle & core_req & ~dbg_grant;

   assign cnt_clr = ~dbg_live | dbg_grant | (state == D_RD);

   starve_counter #(
      .LIM (STARVE_LIM)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc   (dbg_live),
      .clr   (cnt_clr),
      .cnt   (starve_cnt),
      .hit   (starve_hit)
   );

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (1'b1)
         dbg_grant: begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_we ? dbg_wdata : '0;
         end
         core_grant: begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_we ? core_wdata : '0;
         end
         default: ;
      endcase
   end

   assign core_done  = (core_grant & core_we) | (state == C_RD);
   assign core_stall = ~reset | (core_req & ~core_done);

   // Load data is forwarded straight from memory in C_RD and held
   // afterwards so the pipeline sees it in the cycle stall drops.
   assign core_rdata = (state == C_RD) ? mem_rdata : core_rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         dbg_ack      <= 1'b0;
         dbg_rdata    <= '0;
         core_rdata_q <= '0;
      end else begin
         dbg_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (dbg_grant) begin
                  if (dbg_we) dbg_ack <= 1'b1;
                  else        state   <= D_RD;
               end else if (core_grant && !core_we) begin
                  state <= C_RD;
               end
            end
            C_RD: begin
               core_rdata_q <= mem_rdata;
               state        <= IDLE;
            end
            D_RD: begin
               dbg_rdata <= mem_rdata;
               dbg_ack   <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
